// File: rtl/updown_pkg.sv
// Shared codes for the up/down digit sequencer: mode and state encodings plus
// the digit width helper.
package updown_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_UP_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // Bits needed to hold 0..cnt_max (never less than one).
  function automatic int digit_w(input int cnt_max);
    return (cnt_max < 2) ? 1 : $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/updown_count_ctrl_tick_gen.sv
// Tick divider: counts 0..TICK_DIV-1 while enabled, pulses tick on the last
// count. Synchronous clear dominates enable.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clki,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/updown_count_ctrl.sv
// Digit sequencer: up-wrap, down-wrap or bouncing 0..CNT_MAX count paced by
// tick_gen. Optional IDLE single-step enabled by defining SINGLE_STEP_EN.
module updown_count_ctrl
  import updown_pkg::*;
#(
  parameter  int TICK_DIV   = 50000000,
  parameter  int CNT_MAX    = 9,
  parameter  int HOLD_TICKS = 2,
  localparam int W          = digit_w(CNT_MAX)
) (
  input  logic         clki,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
  input  logic         step,
  output logic [W-1:0] digit,
  output logic         dir,
  output logic         busy,
  output logic         tick_o,
  output logic         wrap_pulse
);

  localparam int            HW    = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_TICKS - 1);
  localparam logic [W-1:0]  MAXD  = W'(CNT_MAX);
  localparam logic [W-1:0]  ONE   = W'(1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [W-1:0]  digit_q, digit_d;
  logic          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          tick;

  // Divider is cleared whenever idle, so every start begins a fresh period.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clki  (clki),
    .rst_n (rst_n),
    .clr   ((state_q == ST_IDLE) | stop),
    .en    (busy),
    .tick  (tick)
  );

  assign busy       = (state_q != ST_IDLE);
  assign tick_o     = tick;
  assign digit      = digit_q;
  assign dir        = dir_q;
  assign wrap_pulse = wrap_q;

  logic [W-1:0] up_nxt, dn_nxt;
  logic         up_wrap, dn_wrap;

  assign up_wrap = (digit_q == MAXD);
  assign dn_wrap = (digit_q == '0);
  assign up_nxt  = up_wrap ? '0   : digit_q + 1'b1;
  assign dn_nxt  = dn_wrap ? MAXD : digit_q - 1'b1;

`ifndef SINGLE_STEP_EN
  logic step_unused;
  assign step_unused = step;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    digit_d = digit_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    hold_d  = hold_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d  = mode_e'(mode);
            hold_d  = '0;
            state_d = ST_RUN;
            if (mode_e'(mode) == MODE_DOWN) begin
              digit_d = MAXD;
              dir_d   = 1'b1;
            end else begin
              digit_d = '0;
              dir_d   = 1'b0;
            end
          end
`ifdef SINGLE_STEP_EN
          else if (step) begin
            // Manual step: bounce reverses at an endpoint with no dwell.
            case (mode_q)
              MODE_DOWN: begin
                digit_d = dn_nxt;
                wrap_d  = dn_wrap;
              end
              MODE_BOUNCE: begin
                if (!dir_q) begin
                  if (up_wrap) begin
                    dir_d   = 1'b1;
                    digit_d = MAXD - 1'b1;
                    wrap_d  = 1'b1;
                  end else begin
                    digit_d = digit_q + 1'b1;
                  end
                end else begin
                  if (dn_wrap) begin
                    dir_d   = 1'b0;
                    digit_d = ONE;
                    wrap_d  = 1'b1;
                  end else begin
                    digit_d = digit_q - 1'b1;
                  end
                end
              end
              default: begin
                digit_d = up_nxt;
                wrap_d  = up_wrap;
              end
            endcase
          end
`endif
        end
        ST_RUN: begin
          if (tick) begin
            case (mode_q)
              MODE_DOWN: begin
                digit_d = dn_nxt;
                wrap_d  = dn_wrap;
              end
              MODE_BOUNCE: begin
                // Saturating step; landing on an endpoint enters the dwell.
                if (dir_q) begin
                  digit_d = dn_wrap ? '0 : digit_q - 1'b1;
                  if (digit_q <= ONE) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                  end
                end else begin
                  digit_d = up_wrap ? MAXD : digit_q + 1'b1;
                  if (digit_q >= MAXD - 1'b1) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                  end
                end
              end
              default: begin
                digit_d = up_nxt;
                wrap_d  = up_wrap;
              end
            endcase
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (hold_q == HLAST) begin
              dir_d   = ~dir_q;
              wrap_d  = 1'b1;
              digit_d = dir_q ? digit_q + 1'b1 : digit_q - 1'b1;
              state_d = ST_RUN;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UP;
      digit_q <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      digit_q <= digit_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Scoreboard bench for updown_count_ctrl (TICK_DIV=4, CNT_MAX=9, HOLD_TICKS=2):
// stimulus queues the expected digit/dir/wrap for every tick, a monitor checks them.
module tb_updown_count_ctrl;

  localparam int W = 4;

  logic         clki = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         step = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] digit;
  logic         dir, busy, tick_o, wrap_pulse;

  typedef struct packed {
    logic [3:0] digit;
    logic       dir;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   pend = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  updown_count_ctrl #(.TICK_DIV(4), .CNT_MAX(9), .HOLD_TICKS(2)) dut (
    .clki       (clki),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .step       (step),
    .digit      (digit),
    .dir        (dir),
    .busy       (busy),
    .tick_o     (tick_o),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clki = ~clki;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input bit dr, input bit w);
    exp_t e;
    e.digit = 4'(d);
    e.dir   = dr;
    e.wrap  = w;
    q.push_back(e);
  endtask

  // Monitor: a tick_o cycle pops one expectation, checked after the update edge.
  always @(negedge clki) begin
    if (pend) begin
      check("sb digit", int'(digit), int'(cur.digit));
      check("sb dir", int'(dir), int'(cur.dir));
      check("sb wrap_pulse", int'(wrap_pulse), int'(cur.wrap));
      pend = 1'b0;
    end
    if (tick_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb unexpected tick: got tick_o=1 with digit %0d, expected no tick", digit);
      end else begin
        cur  = q.pop_front();
        pend = 1'b1;
      end
    end
  end

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clki);
    mode  = m;
    start = 1'b1;
    @(negedge clki);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clki);
    stop = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clki);
      if (tick_o) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s timeout: got no tick_o in 100 cycles, expected a tick", name);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clki);
      #1;
      if (q.size() == 0 && !pend) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s drain timeout: got %0d pending entries, expected 0", name, q.size());
  endtask

  task automatic check_zero(input string name);
    check({name, " digit"}, int'(digit), 0);
    check({name, " dir"}, int'(dir), 0);
    check({name, " busy"}, int'(busy), 0);
    check({name, " tick_o"}, int'(tick_o), 0);
    check({name, " wrap_pulse"}, int'(wrap_pulse), 0);
  endtask

  initial begin
    int lat;

    // Reset state
    repeat (3) @(negedge clki);
    #1;
    check_zero("reset");
    @(negedge clki);
    rst_n = 1'b1;
    repeat (2) @(negedge clki);
    #1;
    check_zero("idle after reset");

    // 1: up-wrap, first tick latency, wrap at 9->0
    for (int i = 1; i <= 9; i++) push(i, 1'b0, 1'b0);
    push(0, 1'b0, 1'b1);
    pulse_start(2'b00);
    #1;
    check("up start digit", int'(digit), 0);
    check("up start busy", int'(busy), 1);
    lat = 1;
    while (!tick_o && lat < 50) begin
      @(negedge clki);
      lat++;
    end
    check("first tick latency", lat, 4);
    drain("up");
    pulse_stop();
    #1;
    check("up stop busy", int'(busy), 0);
    check("up stop digit", int'(digit), 0);

    // 2: down-wrap, loads 9 with dir=1, wrap at 0->9
    for (int i = 8; i >= 0; i--) push(i, 1'b1, 1'b0);
    push(9, 1'b1, 1'b1);
    pulse_start(2'b01);
    #1;
    check("down start digit", int'(digit), 9);
    check("down start dir", int'(dir), 1);
    drain("down");
    pulse_stop();

    // 3: bounce with two-tick dwell at each endpoint
    for (int i = 1; i <= 9; i++) push(i, 1'b0, 1'b0);
    push(9, 1'b0, 1'b0);
    push(8, 1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) push(i, 1'b1, 1'b0);
    push(0, 1'b1, 1'b0);
    push(1, 1'b0, 1'b1);
    pulse_start(2'b10);
    #1;
    check("bounce start digit", int'(digit), 0);
    check("bounce start dir", int'(dir), 0);
    drain("bounce");
    pulse_stop();

    // 4: stop on the tick_o cycle at digit 5 discards that tick
    for (int i = 1; i <= 5; i++) push(i, 1'b0, 1'b0);
    push(5, 1'b0, 1'b0);
    pulse_start(2'b00);
    for (int i = 0; i < 6; i++) wait_tick("stop-on-tick");
    pulse_stop();
    #1;
    check("stop on tick digit", int'(digit), 5);
    check("stop on tick busy", int'(busy), 0);
    @(negedge clki);
    start = 1'b1;
    stop  = 1'b1;
    mode  = 2'b01;
    @(negedge clki);
    start = 1'b0;
    stop  = 1'b0;
    #1;
    check("start+stop busy", int'(busy), 0);
    check("start+stop digit", int'(digit), 5);
    repeat (8) @(negedge clki);
    #1;
    check("start+stop still idle", int'(busy), 0);

    // 5: async reset while dwelling at 9, then restart from 0
    for (int i = 1; i <= 9; i++) push(i, 1'b0, 1'b0);
    pulse_start(2'b10);
    drain("to hold");
    rst_n = 1'b0;
    #1;
    check_zero("reset mid-hold");
    @(negedge clki);
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) push(i, 1'b0, 1'b0);
    pulse_start(2'b00);
    #1;
    check("restart digit", int'(digit), 0);
    check("restart busy", int'(busy), 1);
    drain("restart");
    pulse_stop();
    #1;
    check("idle digit 9", int'(digit), 9);

    // 6: single step from 9 in up mode
    @(negedge clki);
    step = 1'b1;
    @(negedge clki);
    step = 1'b0;
    #1;
`ifdef SINGLE_STEP_EN
    check("step digit", int'(digit), 0);
    check("step wrap_pulse", int'(wrap_pulse), 1);
`else
    check("step ignored digit", int'(digit), 9);
    check("step ignored wrap_pulse", int'(wrap_pulse), 0);
`endif
    @(negedge clki);
    #1;
    check("step wrap one cycle", int'(wrap_pulse), 0);
    check("step busy", int'(busy), 0);

    check("queue empty at end", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
